pipeline_ctrl: RTL

- Central hazard and sequencing controller for the 16-bit-instruction, 8-bit-PC in-order pipeline.
- Drives the fetch stage's stall, flush, PC_sel and branch_target inputs, and the decode/execute bubble and flush strobes.
- Resolves three hazard classes: taken-branch redirect, load-use, and multi-cycle-unit busy.
- Gates pipeline start after reset and latches core halt once a halt instruction retires.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/hazard_detect.sv | 15 +
 rtl/pipeline_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the in-order pipeline controller
package pipe_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;
    localparam int          ADDR_W_DEF  = 8;
    localparam int          REG_W_DEF   = 4;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard compare between decode sources and execute load destination
module hazard_detect #(
    parameter int REG_W = pipe_pkg::REG_W_DEF
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu_hazard
);
    assign lu_hazard = id_valid && ex_is_load && (ex_rd != '0) &&
                       ((ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller driving fetch/decode/execute strobes
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_uses_rs2,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_br_valid,
    input  logic              ex_br_taken,
    input  logic [ADDR_W-1:0] ex_br_target,
    input  logic              mc_busy,
    input  logic              wb_halt,
    output logic              stall,
    output logic              flush,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] branch_target,
    output logic              id_stall,
    output logic              id_flush,
    output logic              ex_bubble,
    output logic              core_halted,
    output logic [CNT_W-1:0]  stall_count
);
    state_t     state, state_nx;
    logic [1:0] fcnt, fcnt_nx;
    logic       lu_hazard;

    hazard_detect #(.REG_W(REG_W)) u_hd (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .lu_hazard   (lu_hazard)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fcnt        <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
            if (stall && state != IDLE && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx      = state;
        fcnt_nx       = fcnt;
        stall         = 1'b0;
        flush         = 1'b0;
        pc_sel        = 1'b0;
        branch_target = '0;
        id_stall      = 1'b0;
        id_flush      = 1'b0;
        ex_bubble     = 1'b0;
        core_halted   = 1'b0;
        case (state)
            IDLE: begin
                stall = 1'b1;
                if (start) state_nx = RUN;
            end
            RUN: begin
                if (wb_halt) begin
                    stall    = 1'b1;
                    id_flush = 1'b1;
                    state_nx = HALT;
                end else if (ex_br_valid && ex_br_taken) begin
                    pc_sel        = 1'b1;
                    branch_target = ex_br_target;
                    flush         = 1'b1;
                    id_flush      = 1'b1;
                    ex_bubble     = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = FLUSH;
                        fcnt_nx  = 2'(FLUSH_CYCLES - 2);
                    end
                end else if (lu_hazard) begin
                    stall     = 1'b1;
                    id_stall  = 1'b1;
                    ex_bubble = 1'b1;
                end else if (mc_busy) begin
                    stall    = 1'b1;
                    id_stall = 1'b1;
                end
            end
            FLUSH: begin
                // branches seen here come from squashed slots and are ignored
                flush    = 1'b1;
                id_flush = 1'b1;
                if (wb_halt) state_nx = HALT;
                else if (fcnt == 2'd0) state_nx = RUN;
                else fcnt_nx = fcnt - 2'd1;
            end
            HALT: begin
                stall       = 1'b1;
                core_halted = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
